pitch_detect: RTL and testbench
===============================

PITCH_DETECT -- requirements
Module: pitch_detect

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 20, width of the sample-period counter.
REQ-002 SHALL have parameter HYST, default 64, negative arming threshold magnitude in LSBs.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_valid_in  input  1  qualifies sample_in for the current cycle.
REQ-006 SHALL have port sample_in  input  SYNTH_WIDTH signed  oscillator sample under measurement.
REQ-007 SHALL have port phase_incr_out  output  SYNTH_PHASE_ACC_BITS  estimated phase increment per sample.
REQ-008 SHALL have port period_out  output  PERIOD_BITS  last measured period, in valid samples.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse when phase_incr_out/period_out update.
REQ-010 SHALL have port locked_out  output  1  high while consecutive periods are being measured.

Function
REQ-011 SHALL count only cycles with sample_valid_in high; all other cycles hold the detector state.
REQ-012 SHALL arm when an accepted sample is <= -HYST, and detect a rising crossing on the first accepted sample >= 0 while armed; detection disarms.
REQ-013 SHALL use states IDLE (no crossing seen), MEASURE (counting), DIVIDE (divider busy); reset enters IDLE.
REQ-014 IDLE -> MEASURE on first crossing; counter loads 1 on that sample (counts the crossing sample).
REQ-015 In MEASURE, counter increments per accepted sample; on crossing, the counter value is latched as the period, the counter reloads 1, and the state goes to DIVIDE if period >= 2.
REQ-016 Period < 2 SHALL be discarded with no output; state stays MEASURE.
REQ-017 Counter SHALL saturate at 2^PERIOD_BITS-1; a crossing with a saturated counter SHALL be discarded, deassert locked_out, and restart counting.
REQ-018 DIVIDE SHALL compute floor(2^SYNTH_PHASE_ACC_BITS / period) using a restoring serial divider, one quotient bit per clock, SYNTH_PHASE_ACC_BITS cycles.
REQ-019 A quotient >= 2^SYNTH_PHASE_ACC_BITS SHALL saturate to all ones.
REQ-020 valid_out SHALL pulse exactly SYNTH_PHASE_ACC_BITS+2 clocks after the crossing sample is accepted; outputs update in that same cycle and hold afterwards.
REQ-021 Sample counting and crossing detection SHALL continue during DIVIDE; a crossing during DIVIDE SHALL restart the counter but its period is dropped (no queueing).
REQ-022 locked_out SHALL assert with the first valid_out and deassert on saturation (REQ-017) or reset.

Reset
REQ-023 On rst_in low, all state SHALL clear asynchronously: phase_incr_out=0, period_out=0, valid_out=0, locked_out=0, disarmed, counter=0, state IDLE.
REQ-024 Reset mid-DIVIDE SHALL abort the division with no valid_out.
REQ-025 Release SHALL be synchronized: state updates begin on the second clk_in edge after rst_in rises.

Configuration
REQ-026 Macro PITCH_DETECT_AVG_EN, when defined, SHALL keep the last 4 accepted periods and divide 2^(SYNTH_PHASE_ACC_BITS+2) by their sum (PERIOD_BITS+2 bits); period_out reports sum>>2; valid_out and locked_out are suppressed until 4 periods are collected.
REQ-027 Without PITCH_DETECT_AVG_EN, SHALL use the single latest period as in REQ-018.

Structure
REQ-028 SYNTH_WIDTH and SYNTH_PHASE_ACC_BITS SHALL come from the constants package; the state enum typedef SHALL be added there.
REQ-029 The divider SHALL be a sub-module serial_div (start/busy/done handshake, parameterized dividend and divisor widths).

Verification
REQ-030 Square input +1000/-1000, period 100 samples, every cycle valid -> second crossing onward valid_out with period_out=100, phase_incr_out=42949672 (N=32).
REQ-031 Triangle oscillator with phase_incr_in=2^24, N=32 -> period_out=256, phase_incr_out=16777216, locked_out high after first update.
REQ-032 Input oscillating between -30 and +30 (HYST=64) -> no valid_out, locked_out stays 0.
REQ-033 sample_valid_in toggling 50% with period 100 valid samples -> period_out=100, not 200.
REQ-034 Constant -1000 input after lock, PERIOD_BITS=8 -> counter saturates at 255, next crossing is discarded, locked_out drops.
REQ-035 rst_in pulsed low 5 cycles into DIVIDE -> no valid_out, all outputs 0, re-lock after two subsequent crossings.

Source files
------------

// File: rtl/pitch_detect_pkg.sv
// ---------------------------------------------------------------------------
// pitch_detect_pkg
//   Shared constants for the oscillator pitch detector.
//   SYNTH_WIDTH          : width of the signed oscillator sample
//   SYNTH_PHASE_ACC_BITS : width of the synth phase accumulator (N); the
//                          detector estimates floor(2^N / period)
//   pd_state_e           : detector control states
//   The optional averaging build is selected with PITCH_DETECT_AVG_EN
//   (see pitch_detect.sv).
// ---------------------------------------------------------------------------
package pitch_detect_pkg;

  localparam int SYNTH_WIDTH          = 16;
  localparam int SYNTH_PHASE_ACC_BITS = 32;

  // IDLE    : no rising crossing seen since reset
  // MEASURE : counting accepted samples between crossings
  // DIVIDE  : serial divider busy turning a period into a phase increment
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } pd_state_e;

endpackage : pitch_detect_pkg

// File: rtl/serial_div.sv
// ---------------------------------------------------------------------------
// serial_div
//   Restoring serial divider producing one quotient bit per clock, Q_W bits
//   in Q_W cycles. The dividend may be wider than the quotient: its bits
//   above Q_W preload the partial remainder. If that preload is already
//   >= divisor the true quotient does not fit in Q_W bits, and the result
//   saturates to all ones (this also covers a zero divisor).
//
//   Ports
//     clk_in     : clock, rising edge
//     rst_in     : asynchronous active-low reset; aborts any division
//     i_start    : load operands and begin (ignored while busy)
//     i_dividend : DVD_W-bit unsigned dividend
//     i_divisor  : DVS_W-bit unsigned divisor
//     o_busy     : high while quotient bits are being produced
//     o_done     : one-cycle pulse when o_quot is final
//     o_quot     : Q_W-bit quotient (held until the next start)
// ---------------------------------------------------------------------------
module serial_div #(
  parameter int DVD_W = 33,
  parameter int DVS_W = 20,
  parameter int Q_W   = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [Q_W-1:0]   o_quot
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [DVS_W:0]   r_rem;
  logic [Q_W-1:0]   r_dvd;
  logic [Q_W-1:0]   r_quot;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W:0]   w_trial;
  logic [DVS_W:0]   w_diff;
  logic             w_ge;
  logic [DVS_W:0]   w_top;

  always_comb begin
    // Remainder stays below the divisor between steps, so its low DVS_W
    // bits shifted left plus the next dividend bit never lose information.
    w_trial = {r_rem[DVS_W-1:0], r_dvd[Q_W-1]};
    w_ge    = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial - {1'b0, r_dvs};
    w_top   = (DVS_W+1)'(i_dividend[DVD_W-1:Q_W]);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_rem  <= w_top;
        r_dvd  <= i_dividend[Q_W-1:0];
        r_dvs  <= i_divisor;
        r_quot <= '0;
        r_ovf  <= (w_top >= {1'b0, i_divisor});
        r_cnt  <= CNT_W'(Q_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_ge ? w_diff : w_trial;
        r_quot <= {r_quot[Q_W-2:0], w_ge};
        r_dvd  <= {r_dvd[Q_W-2:0], 1'b0};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_ovf ? '1 : r_quot;

endmodule : serial_div

// File: rtl/pitch_detect.sv
// ---------------------------------------------------------------------------
// pitch_detect
//   Measures the period of an oscillator in accepted samples by timing
//   rising zero crossings (with a negative arming threshold for noise
//   immunity) and converts it to a phase increment floor(2^N / period),
//   N = SYNTH_PHASE_ACC_BITS, using the serial_div sub-module.
//
//   Build option
//     PITCH_DETECT_AVG_EN : when defined, the last four accepted periods are
//                           summed and 2^(N+2) / sum is reported; period_out
//                           shows sum>>2; no output or lock until four
//                           periods have been collected.
//
//   Parameters
//     PERIOD_BITS : width of the sample-period counter
//     HYST        : arming threshold magnitude (arm on sample <= -HYST)
//
//   Ports
//     clk_in          : clock, rising edge
//     rst_in          : asynchronous active-low reset, synchronized release
//     sample_valid_in : qualifies sample_in this cycle
//     sample_in       : signed oscillator sample
//     phase_incr_out  : estimated phase increment per sample
//     period_out      : last measured period in accepted samples
//     valid_out       : one-cycle pulse when the outputs update
//     locked_out      : high while consecutive periods are being measured
// ---------------------------------------------------------------------------
module pitch_detect
  import pitch_detect_pkg::*;
#(
  parameter int PERIOD_BITS = 20,
  parameter int HYST        = 64
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            sample_valid_in,
  input  logic signed [SYNTH_WIDTH-1:0]   sample_in,
  output logic [SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
  output logic [PERIOD_BITS-1:0]          period_out,
  output logic                            valid_out,
  output logic                            locked_out
);

  localparam int N = SYNTH_PHASE_ACC_BITS;

`ifdef PITCH_DETECT_AVG_EN
  localparam int DVS_W = PERIOD_BITS + 2;
  localparam int DVD_W = N + 3;
`else
  localparam int DVS_W = PERIOD_BITS;
  localparam int DVD_W = N + 1;
`endif

  // Dividend is a single one in the MSB: 2^N (or 2^(N+2) when averaging).
  localparam logic [DVD_W-1:0]              DIVIDEND = {1'b1, {(DVD_W-1){1'b0}}};
  localparam logic [PERIOD_BITS-1:0]        CNT_MAX  = '1;
  localparam logic [PERIOD_BITS-1:0]        CNT_ONE  = PERIOD_BITS'(1);
  localparam logic [PERIOD_BITS-1:0]        CNT_TWO  = PERIOD_BITS'(2);
  localparam logic signed [SYNTH_WIDTH-1:0] NEG_HYST = SYNTH_WIDTH'(-HYST);

  // Release qualifier: cleared asynchronously, set by the first clock after
  // rst_in rises, so detector state first moves on the second edge.
  logic                   r_run;

  pd_state_e              r_state;
  logic                   r_armed;
  logic [PERIOD_BITS-1:0] r_cnt;
  logic                   r_start;
  logic [DVS_W-1:0]       r_divisor;
  logic [PERIOD_BITS-1:0] r_pend;
  logic [N-1:0]           r_phase;
  logic [PERIOD_BITS-1:0] r_period;
  logic                   r_valid;
  logic                   r_locked;

  logic                   w_acc;
  logic                   w_arm;
  logic                   w_cross;
  logic                   w_sat;
  logic [PERIOD_BITS-1:0] w_cnt_inc;
  logic                   w_div_busy;
  logic                   w_div_done;
  logic [N-1:0]           w_quot;

`ifdef PITCH_DETECT_AVG_EN
  // Three previous periods; together with the one just measured they form
  // the four-period window.
  logic [PERIOD_BITS-1:0] r_hist [3];
  logic [1:0]             r_nhist;
  logic [DVS_W-1:0]       w_sum;

  always_comb begin
    w_sum = DVS_W'(r_cnt) + DVS_W'(r_hist[0]) + DVS_W'(r_hist[1]) + DVS_W'(r_hist[2]);
  end
`endif

  always_comb begin
    w_acc     = r_run & sample_valid_in;
    w_arm     = (sample_in <= NEG_HYST);
    w_cross   = r_armed & ~sample_in[SYNTH_WIDTH-1];
    w_sat     = (r_cnt == CNT_MAX);
    w_cnt_inc = w_sat ? r_cnt : r_cnt + CNT_ONE;
  end

  serial_div #(
    .DVD_W (DVD_W),
    .DVS_W (DVS_W),
    .Q_W   (N)
  ) u_div (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_start    (r_start),
    .i_dividend (DIVIDEND),
    .i_divisor  (r_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_run     <= 1'b0;
      r_state   <= IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_divisor <= '0;
      r_pend    <= '0;
      r_phase   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
`ifdef PITCH_DETECT_AVG_EN
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
      r_nhist   <= '0;
`endif
    end else begin
      r_run   <= 1'b1;
      r_start <= 1'b0;
      r_valid <= 1'b0;

      if (r_run) begin
        if (w_acc) begin
          if (w_arm) begin
            r_armed <= 1'b1;
          end else if (w_cross) begin
            r_armed <= 1'b0;
          end
        end

        if (w_div_done) begin
          r_phase  <= w_quot;
          r_period <= r_pend;
          r_valid  <= 1'b1;
          r_locked <= 1'b1;
        end

        case (r_state)
          IDLE: begin
            if (w_acc && w_cross) begin
              r_cnt   <= CNT_ONE;
              r_state <= MEASURE;
            end
          end

          MEASURE, DIVIDE: begin
            if (w_acc) begin
              if (w_cross) begin
                // Every crossing starts a new period, even when the one it
                // closes is thrown away (too short, saturated, or divider busy).
                r_cnt <= CNT_ONE;
                if (w_sat) begin
                  r_locked <= 1'b0;
`ifdef PITCH_DETECT_AVG_EN
                  r_nhist  <= '0;
`endif
                end else if (r_state == MEASURE && r_cnt >= CNT_TWO && !w_div_busy) begin
`ifdef PITCH_DETECT_AVG_EN
                  r_hist[0] <= r_cnt;
                  r_hist[1] <= r_hist[0];
                  r_hist[2] <= r_hist[1];
                  if (r_nhist == 2'd3) begin
                    r_start   <= 1'b1;
                    r_divisor <= w_sum;
                    r_pend    <= PERIOD_BITS'(w_sum >> 2);
                    r_state   <= DIVIDE;
                  end else begin
                    r_nhist <= r_nhist + 2'd1;
                  end
`else
                  r_start   <= 1'b1;
                  r_divisor <= r_cnt;
                  r_pend    <= r_cnt;
                  r_state   <= DIVIDE;
`endif
                end
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
            if (r_state == DIVIDE && w_div_done) begin
              r_state <= MEASURE;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign phase_incr_out = r_phase;
  assign period_out     = r_period;
  assign valid_out      = r_valid;
  assign locked_out     = r_locked;

endmodule : pitch_detect

// File: tb/tb_pitch_detect.sv
// ---------------------------------------------------------------------------
// tb_pitch_detect
//   Directed bench for pitch_detect: a table of waveform records with
//   hand-computed period / phase increment / lock expectations, plus
//   sequences for latency, asynchronous reset mid-division and counter
//   saturation (second instance with PERIOD_BITS = 8).
// ---------------------------------------------------------------------------
module tb_pitch_detect;
  import pitch_detect_pkg::*;

  localparam int NB = SYNTH_PHASE_ACC_BITS;

  typedef struct {
    int          kind;     // 0 square +-1000, 1 triangle 2^24 step, 2 square +-30
    int          hi;       // samples high per period (square kinds)
    int          lo;       // samples low per period, starting low
    bit          half;     // sample_valid_in only on every other cycle
    int          nsamp;    // accepted samples to drive
    bit          exp_v;    // any valid_out expected
    int          exp_per;
    logic [31:0] exp_ph;
    bit          exp_lk;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic va = 1'b0, vb = 1'b0;
  logic signed [SYNTH_WIDTH-1:0] sa = '0, sb = '0;
  logic [NB-1:0] ph_a, ph_b;
  logic [19:0]   per_a;
  logic [7:0]    per_b;
  logic          vo_a, vo_b, lk_a, lk_b;

  pitch_detect u_dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .sample_valid_in (va),
    .sample_in       (sa),
    .phase_incr_out  (ph_a),
    .period_out      (per_a),
    .valid_out       (vo_a),
    .locked_out      (lk_a)
  );

  pitch_detect #(.PERIOD_BITS(8)) u_dut8 (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .sample_valid_in (vb),
    .sample_in       (sb),
    .phase_incr_out  (ph_b),
    .period_out      (per_b),
    .valid_out       (vo_b),
    .locked_out      (lk_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   vcnt_a = 0, vcnt_b = 0, vcyc_a = 0, dbl = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge clk) begin
    if (vo_a) begin
      vcnt_a = vcnt_a + 1;
      vcyc_a = cyc;
    end
    if (vo_b) vcnt_b = vcnt_b + 1;
    if ((vo_a && pv_a) || (vo_b && pv_b)) dbl = dbl + 1;
    pv_a = vo_a;
    pv_b = vo_b;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic signed [SYNTH_WIDTH-1:0] s);
    va = v; sa = s; vb = 1'b0; sb = '0;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic signed [SYNTH_WIDTH-1:0] s);
    vb = v; sb = s; va = 1'b0; sa = '0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step_a(1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
  endtask

  function automatic logic signed [SYNTH_WIDTH-1:0] gen(input vec_t v, input int idx);
    logic [31:0] p;
    logic [15:0] t;
    int          per;
    per = v.hi + v.lo;
    case (v.kind)
      1: begin
        p = 32'(idx) << 24;
        t = p[31] ? ~p[30:15] : p[30:15];
        return $signed(t ^ 16'h8000);
      end
      2:       return ((idx % per) < v.lo) ? -16'sd30 : 16'sd30;
      default: return ((idx % per) < v.lo) ? -16'sd1000 : 16'sd1000;
    endcase
  endfunction

  vec_t vt [8];
  vec_t sq100, sq254;
  int   base, acc_cyc;

  initial begin
    vt[0] = '{0, 50, 50, 1'b0,  500, 1'b1, 100, 32'd42949672,   1'b1};
    vt[1] = '{1,  0,  0, 1'b0, 1024, 1'b1, 256, 32'd16777216,   1'b1};
    vt[2] = '{2, 10, 10, 1'b0,  400, 1'b0,   0, 32'd0,          1'b0};
    vt[3] = '{0, 50, 50, 1'b1,  500, 1'b1, 100, 32'd42949672,   1'b1};
    vt[4] = '{0, 25, 25, 1'b0,  300, 1'b1,  50, 32'd85899345,   1'b1};
    vt[5] = '{0,  3,  4, 1'b0,  200, 1'b1,   7, 32'd613566756,  1'b1};
    vt[6] = '{0,  1,  1, 1'b0,  200, 1'b1,   2, 32'h80000000,   1'b1};
    vt[7] = '{0,  1,  2, 1'b0,  200, 1'b1,   3, 32'd1431655765, 1'b1};
    sq100 = vt[0];
    sq254 = '{0, 1, 253, 1'b0, 0, 1'b1, 254, 32'd16909320, 1'b1};

    // Outputs while reset is held
    idle(3);
    check("rst_phase",  64'(ph_a),  64'd0);
    check("rst_period", 64'(per_a), 64'd0);
    check("rst_valid",  64'(vo_a),  64'd0);
    check("rst_locked", 64'(lk_a),  64'd0);
    rst_n = 1'b1;
    idle(3);

    // Table of waveforms
    for (int i = 0; i < 8; i++) begin
      do_reset();
      base = vcnt_a;
      for (int idx = 0; idx < vt[i].nsamp; idx++) begin
        if (vt[i].half) step_a(1'b0, -gen(vt[i], idx));
        step_a(1'b1, gen(vt[i], idx));
      end
      idle(40);
      check($sformatf("v%0d_seen_valid", i), 64'(vcnt_a > base), 64'(vt[i].exp_v));
      check($sformatf("v%0d_period", i),     64'(per_a),          64'(vt[i].exp_per));
      check($sformatf("v%0d_phase", i),      64'(ph_a),           64'(vt[i].exp_ph));
      check($sformatf("v%0d_locked", i),     64'(lk_a),           64'(vt[i].exp_lk));
    end

    // Latency from accepting the closing crossing to valid_out
    do_reset();
    acc_cyc = 0;
    for (int idx = 0; idx < 250; idx++) begin
      step_a(1'b1, gen(sq100, idx));
      if (idx == 150) acc_cyc = cyc;
    end
    check("latency",        64'(vcyc_a - acc_cyc), 64'(NB + 2));
    check("lat_period",     64'(per_a),            64'd100);
    check("lat_locked",     64'(lk_a),             64'd1);

    // Asynchronous reset five cycles into a division
    for (int idx = 250; idx < 256; idx++) step_a(1'b1, gen(sq100, idx));
    rst_n = 1'b0;
    #1;
    check("arst_phase",  64'(ph_a),  64'd0);
    check("arst_period", 64'(per_a), 64'd0);
    check("arst_valid",  64'(vo_a),  64'd0);
    check("arst_locked", 64'(lk_a),  64'd0);
    base = vcnt_a;
    for (int idx = 256; idx < 258; idx++) step_a(1'b1, gen(sq100, idx));
    rst_n = 1'b1;
    for (int idx = 258; idx < 400; idx++) step_a(1'b1, gen(sq100, idx));
    check("abort_no_valid", 64'(vcnt_a - base), 64'd0);
    check("abort_unlocked", 64'(lk_a),          64'd0);
    for (int idx = 400; idx < 500; idx++) step_a(1'b1, gen(sq100, idx));
    idle(40);
    check("relock_valids", 64'(vcnt_a - base), 64'd1);
    check("relock_period", 64'(per_a),         64'd100);
    check("relock_locked", 64'(lk_a),          64'd1);

    // Saturation on the 8-bit counter instance
    do_reset();
    for (int idx = 0; idx < 800; idx++) step_b(1'b1, gen(sq254, idx));
    idle(40);
    check("p8_period", 64'(per_b), 64'd254);
    check("p8_phase",  64'(ph_b),  64'(sq254.exp_ph));
    check("p8_locked", 64'(lk_b),  64'd1);
    base = vcnt_b;
    for (int k = 0; k < 300; k++) step_b(1'b1, -16'sd1000);
    step_b(1'b1, 16'sd1000);
    idle(40);
    check("sat_unlocked", 64'(lk_b),          64'd0);
    check("sat_no_valid", 64'(vcnt_b - base), 64'd0);
    check("sat_hold_per", 64'(per_b),         64'd254);
    for (int idx = 0; idx < 300; idx++) step_b(1'b1, gen(sq254, idx));
    idle(40);
    check("sat_relock_valids", 64'(vcnt_b - base), 64'd1);
    check("sat_relock_locked", 64'(lk_b),          64'd1);
    check("sat_relock_period", 64'(per_b),         64'd254);

    check("valid_single_cycle", 64'(dbl), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pitch_detect
